// File: rtl/sensor_command_controller_pkg.sv
// sensor_ctrl_pkg
//   Shared definitions for the sensor command controller: FSM state encoding,
//   request command codes, response status codes and a command validity helper.
package sensor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_ADDR   = 3'd1,
    ST_WAIT_SENSOR = 3'd2,
    ST_SEND_STATUS = 3'd3,
    ST_WAIT_STATUS = 3'd4,
    ST_SEND_DATA   = 3'd5,
    ST_WAIT_DATA   = 3'd6
  } ctrl_state_e;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_TEMP   = 8'h01;
  localparam logic [7:0] CMD_HUMID  = 8'h02;

  localparam logic [7:0] STATUS_OK         = 8'h08;
  localparam logic [7:0] STATUS_SENSOR_ERR = 8'h1F;
  localparam logic [7:0] STATUS_BAD_CMD    = 8'hCF;
  localparam logic [7:0] STATUS_BAD_ADDR   = 8'hEF;
  localparam logic [7:0] STATUS_TIMEOUT    = 8'hAF;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd == CMD_STATUS) || (cmd == CMD_TEMP) || (cmd == CMD_HUMID);
  endfunction

endpackage

// File: rtl/sensor_command_controller_if.sv
// sensor_command_controller_if
//   Bundles the controller's RX, TX, sensor and display signals.
//   master : the controller side (drives tx/sensor requests, display, busy)
//   slave  : the surrounding UART/sensor logic
//   rx_valid/rx_data        received byte strobe and value
//   tx_start/tx_data        transmit request pulse and byte
//   tx_busy/tx_done         transmitter status and completion strobe
//   sensor_request/command/address  sensor transaction request
//   sensor_done/error/data  sensor transaction result
//   display_data            last good data byte
//   busy                    controller not idle
interface sensor_command_controller_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       sensor_request;
  logic [7:0] sensor_command;
  logic [4:0] sensor_address;
  logic       sensor_done;
  logic       sensor_error;
  logic [7:0] sensor_data;
  logic [7:0] display_data;
  logic       busy;

  modport master (
    input  rx_valid, rx_data, tx_busy, tx_done, sensor_done, sensor_error, sensor_data,
    output tx_start, tx_data, sensor_request, sensor_command, sensor_address,
           display_data, busy
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, tx_done, sensor_done, sensor_error, sensor_data,
    input  tx_start, tx_data, sensor_request, sensor_command, sensor_address,
           display_data, busy
  );
endinterface

// File: rtl/sensor_command_controller_watchdog_timer.sv
// watchdog_timer
//   Down-counter that flags when TIMEOUT_CYCLES cycles have elapsed since the
//   last clear while enabled. Only used when SENSOR_TIMEOUT_EN is defined.
//   clock     : divided system clock
//   reset     : asynchronous active-low reset
//   clear_i   : reload the counter
//   enable_i  : count down this cycle
//   expired_o : terminal count reached while enabled
module watchdog_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = LOAD;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= LOAD;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with TIMEOUT_CYCLES-1 on entry, so zero is reached on the
  // TIMEOUT_CYCLES-th cycle spent enabled.
  assign expired_o = enable_i && (count_q == '0);

endmodule

// File: rtl/sensor_command_controller.sv
// sensor_command_controller
//   Sequences one request/response exchange: receives a command byte and an
//   address byte, validates them, runs one sensor transaction, then sends a
//   status byte followed by a data byte. Keeps the last good data byte for
//   the display.
//   clock : divided system clock
//   reset : asynchronous active-low reset
//   bus   : sensor_command_controller_if.master (RX, TX, sensor, display, busy)
//   Optional: define SENSOR_TIMEOUT_EN to abort sensor waits after
//   TIMEOUT_CYCLES cycles with status TIMEOUT.
//
//   state          | meaning
//   ---------------+----------------------------------------------
//   ST_IDLE        | waiting for the command byte
//   ST_WAIT_ADDR   | waiting for the address byte, then validate
//   ST_WAIT_SENSOR | sensor_request high, waiting for sensor_done
//   ST_SEND_STATUS | start status byte once the transmitter is free
//   ST_WAIT_STATUS | waiting for tx_done of the status byte
//   ST_SEND_DATA   | start data byte once the transmitter is free
//   ST_WAIT_DATA   | waiting for tx_done of the data byte
module sensor_command_controller
  import sensor_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clock,
  input  logic                        reset,
  sensor_command_controller_if.master bus
);

  ctrl_state_e state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  status_q;
  logic [7:0]  data_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        sensor_req_q;
  logic [7:0]  sensor_cmd_q;
  logic [4:0]  sensor_addr_q;
  logic [7:0]  display_q;
  logic        sensor_timeout;

`ifdef SENSOR_TIMEOUT_EN
  logic wd_expired;

  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q != ST_WAIT_SENSOR),
    .enable_i  (state_q == ST_WAIT_SENSOR),
    .expired_o (wd_expired)
  );

  assign sensor_timeout = wd_expired;
`else
  assign sensor_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= 8'h00;
      status_q      <= 8'h00;
      data_q        <= 8'h00;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      sensor_req_q  <= 1'b0;
      sensor_cmd_q  <= 8'h00;
      sensor_addr_q <= 5'd0;
      display_q     <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            cmd_q   <= bus.rx_data;
            state_q <= ST_WAIT_ADDR;
          end
        end

        ST_WAIT_ADDR: begin
          if (bus.rx_valid) begin
            if (!cmd_is_valid(cmd_q)) begin
              status_q <= STATUS_BAD_CMD;
              data_q   <= 8'h00;
              state_q  <= ST_SEND_STATUS;
            end else if (bus.rx_data[7:5] != 3'b000) begin
              status_q <= STATUS_BAD_ADDR;
              data_q   <= 8'h00;
              state_q  <= ST_SEND_STATUS;
            end else begin
              sensor_req_q  <= 1'b1;
              sensor_cmd_q  <= cmd_q;
              sensor_addr_q <= bus.rx_data[4:0];
              state_q       <= ST_WAIT_SENSOR;
            end
          end
        end

        ST_WAIT_SENSOR: begin
          // sensor_done wins over a timeout expiring in the same cycle.
          if (bus.sensor_done) begin
            sensor_req_q <= 1'b0;
            if (bus.sensor_error) begin
              status_q <= STATUS_SENSOR_ERR;
              data_q   <= 8'h00;
            end else begin
              status_q  <= STATUS_OK;
              data_q    <= bus.sensor_data;
              display_q <= bus.sensor_data;
            end
            state_q <= ST_SEND_STATUS;
          end else if (sensor_timeout) begin
            sensor_req_q <= 1'b0;
            status_q     <= STATUS_TIMEOUT;
            data_q       <= 8'h00;
            state_q      <= ST_SEND_STATUS;
          end
        end

        ST_SEND_STATUS: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= status_q;
            state_q    <= ST_WAIT_STATUS;
          end
        end

        ST_WAIT_STATUS: begin
          if (bus.tx_done) begin
            state_q <= ST_SEND_DATA;
          end
        end

        ST_SEND_DATA: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= data_q;
            state_q    <= ST_WAIT_DATA;
          end
        end

        ST_WAIT_DATA: begin
          if (bus.tx_done) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start       = tx_start_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.sensor_request = sensor_req_q;
  assign bus.sensor_command = sensor_cmd_q;
  assign bus.sensor_address = sensor_addr_q;
  assign bus.display_data   = display_q;
  assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sensor_command_controller.sv
module tb_sensor_command_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sensor_command_controller_if bus ();

  sensor_command_controller #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic sensor_finish(input logic [7:0] d, input logic err);
    bus.sensor_done  = 1'b1;
    bus.sensor_data  = d;
    bus.sensor_error = err;
    tick();
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
  endtask

  // Waits (bounded) for tx_start, checks the byte, then plays a transmitter
  // that stays busy for busy_cycles and finishes with a tx_done strobe.
  task automatic expect_tx(input string tag, input logic [7:0] exp, input int busy_cycles);
    int n;
    n = 0;
    while (!bus.tx_start && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_byte"}, 32'(bus.tx_data), 32'(exp));
    bus.tx_busy = 1'b1;
    tick();
    check({tag, "_single_pulse"}, 32'(bus.tx_start), 32'd0);
    for (int i = 1; i < busy_cycles; i++) tick();
    check({tag, "_stable"}, 32'(bus.tx_data), 32'(exp));
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    int  cnt;
    logic stray;
    checks   = 0;
    failures = 0;
    rst_n            = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.tx_busy      = 1'b0;
    bus.tx_done      = 1'b0;
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
    bus.sensor_data  = 8'h00;

    repeat (3) tick();
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_sensor_request", 32'(bus.sensor_request), 32'd0);
    check("rst_sensor_command", 32'(bus.sensor_command), 32'h00);
    check("rst_sensor_address", 32'(bus.sensor_address), 32'd0);
    check("rst_display", 32'(bus.display_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Good temperature read from sensor 3, data 0x19.
    send_byte(8'h01);
    check("t1_busy_after_cmd", 32'(bus.busy), 32'd1);
    send_byte(8'h03);
    check("t1_request", 32'(bus.sensor_request), 32'd1);
    check("t1_address", 32'(bus.sensor_address), 32'd3);
    check("t1_command", 32'(bus.sensor_command), 32'h01);
    repeat (3) tick();
    check("t1_request_held", 32'(bus.sensor_request), 32'd1);
    check("t1_no_tx_yet", 32'(bus.tx_start), 32'd0);
    sensor_finish(8'h19, 1'b0);
    check("t1_request_drop", 32'(bus.sensor_request), 32'd0);
    check("t1_display", 32'(bus.display_data), 32'h19);
    check("t1_tx_not_yet", 32'(bus.tx_start), 32'd0);
    tick();
    check("t1_status_start_timing", 32'(bus.tx_start), 32'd1);
    expect_tx("t1_status", 8'h08, 2);
    check("t1_data_not_yet", 32'(bus.tx_start), 32'd0);
    tick();
    check("t1_data_start_timing", 32'(bus.tx_start), 32'd1);
    expect_tx("t1_data", 8'h19, 3);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // sensor_done while idle must be ignored.
    sensor_finish(8'h55, 1'b0);
    check("stray_done_display", 32'(bus.display_data), 32'h19);
    check("stray_done_idle", 32'(bus.busy), 32'd0);

    // Bad command.
    send_byte(8'h07);
    send_byte(8'h03);
    check("t2_no_request", 32'(bus.sensor_request), 32'd0);
    check("t2_no_tx_yet", 32'(bus.tx_start), 32'd0);
    tick();
    check("t2_start_timing", 32'(bus.tx_start), 32'd1);
    expect_tx("t2_status", 8'hCF, 1);
    expect_tx("t2_data", 8'h00, 1);
    check("t2_display", 32'(bus.display_data), 32'h19);
    check("t2_idle", 32'(bus.busy), 32'd0);

    // Bad address.
    send_byte(8'h02);
    send_byte(8'h21);
    check("t3_no_request", 32'(bus.sensor_request), 32'd0);
    expect_tx("t3_status", 8'hEF, 2);
    expect_tx("t3_data", 8'h00, 2);

    // Sensor error.
    send_byte(8'h02);
    send_byte(8'h05);
    check("t4_address", 32'(bus.sensor_address), 32'd5);
    check("t4_command", 32'(bus.sensor_command), 32'h02);
    tick();
    sensor_finish(8'h77, 1'b1);
    check("t4_request_drop", 32'(bus.sensor_request), 32'd0);
    expect_tx("t4_status", 8'h1F, 2);
    expect_tx("t4_data", 8'h00, 2);
    check("t4_display", 32'(bus.display_data), 32'h19);

    // Transmitter busy in SEND_STATUS, plus stray RX bytes mid-transaction.
    send_byte(8'h01);
    send_byte(8'h04);
    send_byte(8'h99);
    bus.tx_busy = 1'b1;
    sensor_finish(8'h42, 1'b0);
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send_byte(8'h02);
      else tick();
      if (bus.tx_start) stray = 1'b1;
    end
    check("t5_held_while_busy", 32'(stray), 32'd0);
    check("t5_still_busy", 32'(bus.busy), 32'd1);
    bus.tx_busy = 1'b0;
    tick();
    check("t5_start_after_busy", 32'(bus.tx_start), 32'd1);
    expect_tx("t5_status", 8'h08, 2);
    expect_tx("t5_data", 8'h42, 2);
    check("t5_display", 32'(bus.display_data), 32'h42);
    check("t5_idle", 32'(bus.busy), 32'd0);
    send_byte(8'h01);
    send_byte(8'h06);
    check("t5_next_address", 32'(bus.sensor_address), 32'd6);
    sensor_finish(8'h11, 1'b0);
    expect_tx("t5b_status", 8'h08, 1);
    expect_tx("t5b_data", 8'h11, 1);

`ifdef SENSOR_TIMEOUT_EN
    // No sensor_done: request drops after 16 cycles, TIMEOUT response.
    send_byte(8'h01);
    send_byte(8'h07);
    cnt = 0;
    while (bus.sensor_request && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t6_timeout_cycles", 32'(cnt), 32'd16);
    expect_tx("t6_status", 8'hAF, 2);
    expect_tx("t6_data", 8'h00, 2);
    check("t6_display", 32'(bus.display_data), 32'h11);
`else
    cnt = 0;
`endif

    // Reset asserted in WAIT_SENSOR aborts asynchronously.
    send_byte(8'h01);
    send_byte(8'h02);
    check("t7_request", 32'(bus.sensor_request), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t7_async_request", 32'(bus.sensor_request), 32'd0);
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_display", 32'(bus.display_data), 32'h00);
    check("t7_address", 32'(bus.sensor_address), 32'd0);
    check("t7_command", 32'(bus.sensor_command), 32'h00);
    check("t7_tx_data", 32'(bus.tx_data), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Partial request discarded by reset.
    send_byte(8'h07);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("t8_idle_after_reset", 32'(bus.busy), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    check("t8_request", 32'(bus.sensor_request), 32'd1);
    check("t8_command", 32'(bus.sensor_command), 32'h00);
    check("t8_address", 32'(bus.sensor_address), 32'd1);
    sensor_finish(8'h33, 1'b0);
    expect_tx("t8_status", 8'h08, 1);
    expect_tx("t8_data", 8'h33, 1);
    check("t8_display", 32'(bus.display_data), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_command_controller.md
# sensor_command_controller

Command sequencer between the UART receiver, the sensor interface and the UART transmitter of the DigitalSensor top level. It accepts a two-byte request (command, sensor address) from the RX path, validates it, drives one sensor transaction, and returns a two-byte response (status, data) through the TX path. It also latches the last good data byte for the seven-segment display and runs entirely on the divided clock.

## Interface
- TIMEOUT_CYCLES, 1_000_000: sensor wait limit in clock cycles; used only with SENSOR_TIMEOUT_EN.
- clock  in  1  divided system clock.
- reset  in  1  asynchronous, active-low; low forces the reset state.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle pulse: start transmitting tx_data.
- tx_data  out  8  byte to send; stable from tx_start until tx_done.
- tx_busy  in  1  transmitter active.
- tx_done  in  1  one-cycle strobe: byte fully sent.
- sensor_request  out  1  level; high for the whole sensor transaction.
- sensor_command  out  8  command code; valid while sensor_request is high.
- sensor_address  out  5  target sensor; valid while sensor_request is high.
- sensor_done  in  1  one-cycle strobe: transaction finished.
- sensor_error  in  1  sampled with sensor_done.
- sensor_data  in  8  sampled with sensor_done.
- display_data  out  8  last data byte returned with STATUS_OK.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_ADDR, WAIT_SENSOR, SEND_STATUS, WAIT_STATUS, SEND_DATA, WAIT_DATA.
- IDLE: rx_valid latches the command byte, then goes to WAIT_ADDR.
- WAIT_ADDR: rx_valid latches the address byte and validates both bytes in the same edge:
  - Command not in {0x00 status, 0x01 temperature, 0x02 humidity}: status 0xCF (BAD_CMD), data 0x00, go to SEND_STATUS.
  - Else if address[7:5] != 0: status 0xEF (BAD_ADDR), data 0x00, go to SEND_STATUS.
  - Else: set sensor_request = 1, drive sensor_command and sensor_address = address[4:0], go to WAIT_SENSOR.
- WAIT_SENSOR: on sensor_done, clear sensor_request and capture sensor_data.
  - sensor_error = 1: status 0x1F (SENSOR_ERR).
  - sensor_error = 0: status 0x08 (OK) and update display_data.
  - Go to SEND_STATUS.
- SEND_STATUS / SEND_DATA: when tx_busy = 0, pulse tx_start with the status or data byte, then go to the matching WAIT state. While tx_busy = 1, hold the state.
- WAIT_STATUS: on tx_done, go to SEND_DATA. WAIT_DATA: on tx_done, go to IDLE.
- Ignored inputs:
  - rx_valid in any state except IDLE and WAIT_ADDR (bytes are dropped, not queued).
  - sensor_done outside WAIT_SENSOR.
  - tx_done outside the WAIT states.
- Every error response carries data byte 0x00. display_data changes only on OK.

## Timing
- Reset values: tx_start 0, tx_data 0x00, sensor_request 0, sensor_command 0x00, sensor_address 0, display_data 0x00, busy 0. State is IDLE.
- Asserting reset mid-operation aborts immediately and drops sensor_request asynchronously. A partially received request is discarded.
- Address byte accepted on edge k:
  - Valid request: sensor_request is high from edge k.
  - Invalid request: tx_start pulses in the cycle after edge k+1 (the SEND_STATUS cycle), provided tx_busy = 0.
- sensor_done sampled on edge m: sensor_request is low after m, and the status tx_start follows in the next cycle.
- tx_done of the status byte on edge n: the data byte's tx_start comes one cycle later when tx_busy = 0.
- tx_start is never high for two consecutive cycles. At most one sensor transaction is outstanding.
- Minimum turnaround from address byte to the first tx_start: 2 cycles.

## Configuration
- SENSOR_TIMEOUT_EN defined: a cycle counter runs in WAIT_SENSOR and clears on entry.
  - If it reaches TIMEOUT_CYCLES-1 without sensor_done, drop sensor_request and send status 0xAF (TIMEOUT) with data 0x00.
  - sensor_done in the same cycle as expiry takes priority.
- SENSOR_TIMEOUT_EN undefined: no counter; the block waits for sensor_done indefinitely.

## Structure
- Package sensor_ctrl_pkg holds:
  - The state enum.
  - Command codes CMD_STATUS, CMD_TEMP and CMD_HUMID.
  - Status codes STATUS_OK 0x08, STATUS_SENSOR_ERR 0x1F, STATUS_BAD_CMD 0xCF, STATUS_BAD_ADDR 0xEF and STATUS_TIMEOUT 0xAF.
- One sub-module, watchdog_timer (clear, enable, expired output), is instantiated only under SENSOR_TIMEOUT_EN.

## Test plan
- Bytes 0x01, 0x03, then sensor_done with data 0x19 and error 0 -> sensor_address 3; TX sends 0x08 then 0x19; display_data becomes 0x19.
- Bytes 0x07, 0x03 -> no sensor_request; TX sends 0xCF, 0x00; display_data unchanged.
- Bytes 0x02, 0x21 -> TX sends 0xEF, 0x00.
- Bytes 0x02, 0x05, then sensor_done with error 1 -> TX sends 0x1F, 0x00; display_data unchanged.
- tx_busy held high for 10 cycles in SEND_STATUS -> tx_start waits; extra rx_valid bytes during the transaction are ignored.
- With SENSOR_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no sensor_done -> sensor_request drops after 16 cycles; TX sends 0xAF, 0x00. Asserting reset during WAIT_SENSOR -> all outputs return to reset values.
